// File: rtl/rr_seg_pkg.sv
// Shared definitions for the rotating-priority display arbiter: FSM
// encoding and the active-low seven-segment digit patterns {a,b,c,d,e,f,g}.
package rr_seg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  localparam logic [6:0] SEG_D0    = 7'b0000001;
  localparam logic [6:0] SEG_D1    = 7'b1001111;
  localparam logic [6:0] SEG_D2    = 7'b0010010;
  localparam logic [6:0] SEG_D3    = 7'b0000110;
  localparam logic [6:0] SEG_D4    = 7'b1001100;
  localparam logic [6:0] SEG_D5    = 7'b0100100;
  localparam logic [6:0] SEG_D6    = 7'b0100000;
  localparam logic [6:0] SEG_D7    = 7'b0001111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_pattern(input logic [ID_W-1:0] digit);
    logic [6:0] pat;
    case (digit)
      3'd0:    pat = SEG_D0;
      3'd1:    pat = SEG_D1;
      3'd2:    pat = SEG_D2;
      3'd3:    pat = SEG_D3;
      3'd4:    pat = SEG_D4;
      3'd5:    pat = SEG_D5;
      3'd6:    pat = SEG_D6;
      default: pat = SEG_D7;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/rr_seg_arbiter_if.sv
// Bundle of the arbiter's request/grant/display signals. The master side
// drives requests; the slave side is the arbiter producing grants.
interface rr_seg_arbiter_if #(
  parameter int HOLD_W = 4
);
  logic [7:0]        req;
  logic              en;
  logic [HOLD_W-1:0] hold;
  logic [7:0]        gnt;
  logic [2:0]        gnt_id;
  logic              gnt_valid;
  logic [6:0]        seg;

  modport master (
    output req, en, hold,
    input  gnt, gnt_id, gnt_valid, seg
  );

  modport slave (
    input  req, en, hold,
    output gnt, gnt_id, gnt_valid, seg
  );
endinterface

// File: rtl/seg7_dec.sv
// Active-low seven-segment decoder for a 3-bit digit; blanks when not valid.
module seg7_dec
  import rr_seg_pkg::*;
(
  input  logic [2:0] digit,
  input  logic       valid,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (valid) begin
      seg = seg_pattern(digit);
    end
  end

endmodule

// File: rtl/rr_seg_arbiter.sv
// Eight-way rotating-priority arbiter with per-grant hold length and a
// seven-segment readout of the current grantee.
module rr_seg_arbiter
  import rr_seg_pkg::*;
#(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        req,
  input  logic              en,
  input  logic [HOLD_W-1:0] hold,
  output logic [7:0]        gnt,
  output logic [2:0]        gnt_id,
  output logic              gnt_valid,
  output logic [6:0]        seg
);

  state_t            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [7:0]        gnt_q, gnt_d;
  logic [2:0]        gnt_id_q, gnt_id_d;
  logic              gnt_valid_q, gnt_valid_d;

  // Requests rotated so that bit 0 is the requester at ptr; the first set
  // bit of req_rot is then the offset of the winner from ptr.
  logic [7:0] req_rot;
  logic [2:0] pick_off;
  logic [2:0] pick_id;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    assign req_rot[gi] = req[ptr_q + 3'(gi)];
  end

  always_comb begin
    pick_off = 3'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick_off = 3'(i);
      end
    end
  end

  assign pick_id = ptr_q + pick_off;

  logic grant_end;
  assign grant_end = (cnt_q == '0) || !req[gnt_id_q] || !en;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    case (state_q)
      IDLE: begin
        if (en && (req != 8'h00)) begin
          gnt_d       = 8'b0000_0001 << pick_id;
          gnt_id_d    = pick_id;
          gnt_valid_d = 1'b1;
          cnt_d       = hold;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        // Any combination of expiry, release and disable is one termination.
        if (grant_end) begin
          gnt_d       = 8'h00;
          gnt_id_d    = 3'd0;
          gnt_valid_d = 1'b0;
          cnt_d       = '0;
          ptr_d       = gnt_id_q + 3'd1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = 8'h00;
        gnt_id_d    = 3'd0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      cnt_q       <= '0;
      gnt_q       <= 8'h00;
      gnt_id_q    <= 3'd0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;

  seg7_dec u_seg7_dec (
    .digit (gnt_id_q),
    .valid (gnt_valid_q),
    .seg   (seg)
  );

endmodule
